// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin 4:1 arbiter: state encoding, sizes and
// the rotating-priority search used for every grant decision.
package arb_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // First requester found scanning ptr, ptr+1, ... (2-bit index wraps mod 4).
    function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [SELW-1:0] ptr);
        logic [SELW-1:0] idx;
        logic [SELW-1:0] pick;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + SELW'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4to1_dw.sv
// Case-based 4:1 select of w0..w3 by s; purely combinational.
module mux4to1_dw
    import arb_pkg::*;
#(
    parameter int DW = 3
) (
    input  logic [SELW-1:0] s,
    input  logic [DW-1:0]   w0,
    input  logic [DW-1:0]   w1,
    input  logic [DW-1:0]   w2,
    input  logic [DW-1:0]   w3,
    output logic [DW-1:0]   y
);

    always_comb begin
        y = w0;
        case (s)
            2'd0: y = w0;
            2'd1: y = w1;
            2'd2: y = w2;
            2'd3: y = w3;
            default: y = w0;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter granting one of four requesters onto a shared 4:1 datapath
// with valid/ready handoff. Define ARB_LOCK_EN to let lock[s] keep a burst on s.
module rr_mux4_arbiter
    import arb_pkg::*;
#(
    parameter int DW      = 3,
    parameter int PTR_RST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   w0,
    input  logic [DW-1:0]   w1,
    input  logic [DW-1:0]   w2,
    input  logic [DW-1:0]   w3,
    input  logic [NREQ-1:0] lock,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [SELW-1:0] s,
    output logic [NREQ-1:0] ack,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [SELW-1:0] s_q, s_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW-1:0] ptr_adv;
    logic            handshake;
    logic            burst_hold;

`ifdef ARB_LOCK_EN
    assign burst_hold = lock[s_q] & req[s_q];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign burst_hold  = 1'b0;
`endif

    assign out_valid = (state_q == GRANT);
    assign busy      = (state_q == GRANT);
    assign s         = s_q;
    assign handshake = out_valid & out_ready & ~rst;
    assign ack       = handshake ? (NREQ'(1) << s_q) : '0;
    assign ptr_adv   = s_q + SELW'(1);

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    s_d     = rr_pick(req, ptr_q);
                end
            end
            GRANT: begin
                if (out_ready) begin
                    if (!burst_hold) begin
                        // Served requester sits at ptr-1, i.e. lowest priority.
                        ptr_d = ptr_adv;
                        if (|req) s_d = rr_pick(req, ptr_adv);
                        else      state_d = IDLE;
                    end
                end else if (!req[s_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            ptr_q   <= SELW'(PTR_RST);
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
        end
    end

    mux4to1_dw #(
        .DW(DW)
    ) u_mux (
        .s (s_q),
        .w0(w0),
        .w1(w1),
        .w2(w2),
        .w3(w3),
        .y (out_data)
    );

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: per-cycle vector table fed through an
// expectation queue, plus hand-written reset and latency/abort sequences.
module tb_rr_mux4_arbiter;

    localparam int DW = 3;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_s;
        logic [3:0] exp_ack;
    } vec_t;

    typedef struct {
        logic          valid;
        logic [1:0]    s;
        logic [3:0]    ack;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] w0, w1, w2, w3;
    logic [3:0]    lock;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    s;
    logic [3:0]    ack;
    logic          busy;

    logic [DW-1:0] wv [4];
    vec_t          vecs[$];
    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter #(
        .DW     (DW),
        .PTR_RST(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .w0       (w0),
        .w1       (w1),
        .w2       (w2),
        .w3       (w3),
        .lock     (lock),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .s        (s),
        .ack      (ack),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic rdy, input logic v, input logic [1:0] sv,
                       input logic [3:0] ak);
        vec_t t;
        t.rst = r; t.req = rq; t.lock = lk; t.rdy = rdy;
        t.exp_valid = v; t.exp_s = sv; t.exp_ack = ak;
        vecs.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   lat;

        wv[0] = 3'b001; wv[1] = 3'b010; wv[2] = 3'b101; wv[3] = 3'b110;
        w0 = wv[0]; w1 = wv[1]; w2 = wv[2]; w3 = wv[3];

        // Cycle-by-cycle vectors: inputs held for one cycle, outputs seen in that cycle.
        // All four requesting, out_ready=1: grants 0,1,2,3,0 with no bubble.
        add(0, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 1, 0, 4'b0001);
        add(0, 4'b1111, 4'b0000, 1, 1, 1, 4'b0010);
        add(0, 4'b1111, 4'b0000, 1, 1, 2, 4'b0100);
        add(0, 4'b1111, 4'b0000, 1, 1, 3, 4'b1000);
        add(0, 4'b0000, 4'b0000, 1, 1, 0, 4'b0001);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Single request on 2, one transfer, back to idle.
        add(0, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 2, 4'b0100);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Request 1 stalled by out_ready=0 for five cycles, then one ack.
        add(0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) add(0, 4'b0010, 4'b0000, 0, 1, 1, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 1, 4'b0010);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Granted requester 3 withdraws: abort, ptr stays at 2 for the next search.
        add(0, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b1000, 4'b0000, 0, 1, 3, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 1, 3, 4'b0000);
        add(0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 1, 2, 4'b0100);
        add(0, 4'b0000, 4'b0000, 1, 1, 3, 4'b1000);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Served requester still high gets lowest priority.
        add(0, 4'b0011, 4'b0000, 1, 0, 0, 4'b0000);
        add(0, 4'b0011, 4'b0000, 1, 1, 0, 4'b0001);
        add(0, 4'b0011, 4'b0000, 1, 1, 1, 4'b0010);
        add(0, 4'b0000, 4'b0000, 1, 1, 0, 4'b0001);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Move ptr back to 0 via requester 3 (wrap 3->0).
        add(0, 4'b1000, 4'b0000, 1, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 3, 4'b1000);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Lock on requester 0.
        add(0, 4'b0011, 4'b0001, 1, 0, 0, 4'b0000);
`ifdef ARB_LOCK_EN
        add(0, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001);
        add(0, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001);
        add(0, 4'b0011, 4'b0000, 1, 1, 0, 4'b0001);
`else
        add(0, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001);
        add(0, 4'b0011, 4'b0001, 1, 1, 1, 4'b0010);
        add(0, 4'b0011, 4'b0000, 1, 1, 0, 4'b0001);
`endif
        add(0, 4'b0000, 4'b0000, 1, 1, 1, 4'b0010);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);
        // Reset during a grant with out_ready=1: no ack, ptr returns to 0.
        add(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000);
        add(1, 4'b0100, 4'b0000, 1, 1, 2, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 0, 4'b0001);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000);

        // Reset for two cycles.
        rst = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_s",     32'(s),         32'd0);
        check("reset_ack",   32'(ack),       32'd0);
        check("reset_busy",  32'(busy),      32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            lock      = vecs[i].lock;
            out_ready = vecs[i].rdy;
            e.valid = vecs[i].exp_valid;
            e.s     = vecs[i].exp_s;
            e.ack   = vecs[i].exp_ack;
            e.data  = wv[vecs[i].exp_s];
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(e.valid));
            check($sformatf("v%0d_busy", i),  32'(busy),      32'(e.valid));
            check($sformatf("v%0d_ack", i),   32'(ack),       32'(e.ack));
            if (e.valid) begin
                check($sformatf("v%0d_s", i),    32'(s),        32'(e.s));
                check($sformatf("v%0d_data", i), 32'(out_data), 32'(e.data));
            end
            @(posedge clk);
            #1;
        end

        // Request->valid latency, bounded wait; ptr is 1 here, only req[0] is high.
        rst = 1'b0; req = 4'b0001; lock = '0; out_ready = 1'b0;
        #1;
        lat = 0;
        while (!out_valid && lat < 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd1);
        check("lat_s",   32'(s),   32'd0);
        repeat (2) begin
            check("stall_data", 32'(out_data), 32'(wv[0]));
            check("stall_ack",  32'(ack),      32'd0);
            @(posedge clk);
            #1;
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ack",   32'(ack),       32'd0);
        req = 4'b1111;
        @(posedge clk);
        #1;
        check("abort_next_s", 32'(s),   32'd1);
        check("abort_next_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
